round2in1: RTL and testbench



---
 rtl/sha3_pkg.sv | 26 ++
 rtl/keccak_round.sv | 30 +++
 rtl/round2in1.sv | 19 +
 tb/tb_round2in1.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// sha3_pkg: shared Keccak-f[1600] constants, rho offsets and lane helpers.
package sha3_pkg;
    localparam int LANE_W = 64;
    localparam int LANES = 25;
    localparam int STATE_W = LANE_W * LANES;
    // Indexed [y][x], matching the published offset table row by row.
    localparam int RHO [5][5] = '{
        '{ 0,  1, 62, 28, 27},
        '{36, 44,  6, 55, 20},
        '{ 3, 10, 43, 25, 39},
        '{41, 45, 15, 21,  8},
        '{18,  2, 61, 56, 14}
    };

    function automatic int lane_pos(input int x, input int y);
        return STATE_W - 1 - LANE_W * (5 * y + x);
    endfunction

    function automatic int rho(input int x, input int y);
        return RHO[y][x];
    endfunction

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int n);
        return (v << n) | (v >> (LANE_W - n));
    endfunction
endpackage

// File: rtl/keccak_round.sv
// keccak_round: one combinational Keccak-f[1600] round (theta, rho, pi, chi, iota).
module keccak_round
    import sha3_pkg::*;
(
    input  logic [STATE_W-1:0] in,
    input  logic [LANE_W-1:0]  rc,
    output logic [STATE_W-1:0] out
);
    logic [LANE_W-1:0] a [5][5];
    logic [LANE_W-1:0] b [5][5];
    logic [LANE_W-1:0] c [5];
    logic [LANE_W-1:0] d [5];

    for (genvar x = 0; x < 5; x++) begin : g_col
        assign c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
        assign d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
        for (genvar y = 0; y < 5; y++) begin : g_lane
            assign a[x][y] = in[lane_pos(x, y) -: LANE_W];
            // theta folded into the rho+pi move
            assign b[y][(2 * x + 3 * y) % 5] = rotl(a[x][y] ^ d[x], rho(x, y));
            if (x == 0 && y == 0) begin : g_iota
                assign out[lane_pos(x, y) -: LANE_W] =
                    b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]) ^ rc;
            end else begin : g_chi
                assign out[lane_pos(x, y) -: LANE_W] =
                    b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
            end
        end
    end
endmodule

// File: rtl/round2in1.sv
// round2in1: two chained Keccak-f[1600] rounds evaluated combinationally.
module round2in1
    import sha3_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] in,
    input  logic [LANE_W-1:0]  rc1,
    input  logic [LANE_W-1:0]  rc2,
    output logic [STATE_W-1:0] out
);
    logic [STATE_W-1:0] mid;
    // clk and reset exist only for interface uniformity with the clocked core
    logic unused_ok;
    assign unused_ok = &{clk, reset};

    keccak_round u_r1 (.in(in),  .rc(rc1), .out(mid));
    keccak_round u_r2 (.in(mid), .rc(rc2), .out(out));
endmodule

// File: tb/tb_round2in1.sv
// tb_round2in1: vector table, random composition and clock/reset independence checks.
module tb_round2in1;
    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          reset = 1'b1;
    logic [1599:0] din = '0;
    logic [63:0]   rc1 = '0;
    logic [63:0]   rc2 = '0;
    logic [1599:0] dout;
    int            checks = 0;
    int            failures = 0;
    int            rho_t [25];

    round2in1 dut (.clk(clk), .reset(reset), .in(din), .rc1(rc1), .rc2(rc2), .out(dout));

    always #5 if (clk_en) clk = ~clk;

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        logic [127:0] t;
        t = {v, v} >> (64 - n);
        return t[63:0];
    endfunction

    // Reference round on a flat lane array, lane k = x + 5y
    function automatic logic [1599:0] ref_round(input logic [1599:0] s, input logic [63:0] rc);
        logic [63:0]   a [25];
        logic [63:0]   b [25];
        logic [63:0]   c [5];
        logic [1599:0] r;
        int            sx;
        for (int k = 0; k < 25; k++) a[k] = s[1599 - 64 * k -: 64];
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++) c[x] ^= a[x + 5 * y];
        end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) a[x + 5 * y] ^= c[(x + 4) % 5] ^ rot(c[(x + 1) % 5], 1);
        for (int bx = 0; bx < 5; bx++)
            for (int by = 0; by < 5; by++) begin
                sx = (bx + 3 * by) % 5;
                b[bx + 5 * by] = rot(a[sx + 5 * bx], rho_t[sx + 5 * bx]);
            end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[1599 - 64 * (x + 5 * y) -: 64] =
                    b[x + 5 * y] ^ (~b[(x + 1) % 5 + 5 * y] & b[(x + 2) % 5 + 5 * y]);
        r[1599 -: 64] ^= rc;
        return r;
    endfunction

    function automatic logic [1599:0] ref2(input logic [1599:0] s, input logic [63:0] a, input logic [63:0] b);
        return ref_round(ref_round(s, a), b);
    endfunction

    task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int k = 0; k < 25; k++)
                if (act[1599 - 64 * k -: 64] !== exp[1599 - 64 * k -: 64]) begin
                    $display("FAIL %s lane%0d got=%h exp=%h", name, k,
                             act[1599 - 64 * k -: 64], exp[1599 - 64 * k -: 64]);
                    break;
                end
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int k = 0; k < 50; k++) s[32 * k +: 32] = $urandom;
        return s;
    endfunction

    typedef struct {
        logic [1599:0] din;
        logic [63:0]   rc1;
        logic [63:0]   rc2;
        logic [1599:0] exp;
    } vec_t;

    initial begin
        vec_t          tbl [5];
        logic [1599:0] kv, kv_exp, held, alt, swp;
        logic [63:0]   ra, rb;
        int            x, y, nx, act_diff, exp_diff;
        // rho offsets derived from the (t+1)(t+2)/2 walk, not copied from the table
        x = 1; y = 0;
        rho_t[0] = 0;
        for (int t = 0; t < 24; t++) begin
            rho_t[x + 5 * y] = ((t + 1) * (t + 2) / 2) % 64;
            nx = y; y = (2 * x + 3 * y) % 5; x = nx;
        end
        kv = {64'h6baa9455e3e70682, 64'hd4713d60c8a70639, 64'h7a024204f7c1bd87, 64'h8133287637ebdcd9, 64'h4f65d4d9259f4329,
              64'haf19922ad9b8a714, 64'h8f4ff31e78de5857, 64'h6f25e2a25a921187, 64'h42af9fc385776e9a, 64'h03983ca8ea7e9d49,
              64'hd71037d1b83e90ec, 64'ha0116be5ab0c1681, 64'h55485822de1b372a, 64'h101fbcccded733e8, 64'h9148624feac1c14f,
              64'h1759edc372ae2244, 64'h1beb37117d41e602, 64'h8c25166a1ff39849, 64'h71eacd0549a3e80e, 64'hcc45782198a6416d,
              64'h935ddd725129fb7c, 64'h2f1205544a5308cc, 64'h2fcd81b5d24bace4, 64'h79fdef7c42930b33, 64'he07405eb215663ab};
        kv_exp = ref2(kv, 64'h864a7a50b48d73f1, 64'h864a7a50b48d73f1);
        tbl[0] = '{'0, 64'h0, 64'h0, '0};
        tbl[1] = '{'0, 64'h0, 64'hDEADBEEF01234567, {64'hDEADBEEF01234567, 1536'h0}};
        tbl[2] = '{kv, 64'h864a7a50b48d73f1, 64'h864a7a50b48d73f1, kv_exp};
        tbl[3] = '{'0, 64'h1, 64'h0, ref2('0, 64'h1, 64'h0)};
        tbl[4] = '{kv, 64'h1, 64'h8082, ref2(kv, 64'h1, 64'h8082)};
        #2;
        for (int i = 0; i < 5; i++) begin
            din = tbl[i].din; rc1 = tbl[i].rc1; rc2 = tbl[i].rc2;
            #1;
            check($sformatf("vec%0d", i), dout, tbl[i].exp);
        end
        din = kv; rc1 = 64'h864a7a50b48d73f1; rc2 = rc1;
        #1;
        check64("known_l0",  dout[1599:1536], 64'h788dff2395ebaf99);
        check64("known_l1",  dout[1535:1472], 64'hdcbf7f45dcc05849);
        check64("known_l22", dout[191:128],   64'h04c4fd2a07df850c);
        check64("known_l23", dout[127:64],    64'he1247c4f9f913b6e);
        check64("known_l24", dout[63:0],      64'hd5fcdb016d06dd68);
        // reset low and a running clock must not move the output
        reset = 1'b0;
        clk_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_low_cyc%0d", i), dout, kv_exp);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", dout, kv_exp);
        clk_en = 1'b0;
        #20;
        held = clk;
        alt = rand_state();
        din = alt;
        #1;
        check("comb_new_in", dout, ref2(alt, rc1, rc2));
        din = kv;
        #1;
        check("comb_back", dout, kv_exp);
        check64("clk_stopped", {63'b0, clk}, held[63:0]);
        act_diff = 0;
        exp_diff = 0;
        for (int i = 0; i < 1000; i++) begin
            din = rand_state();
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) begin ra = 64'h1; rb = 64'h8082; end
            if (i == 1) begin ra = 64'h8082; rb = 64'h1; end
            if (i == 2) rb = ra;
            rc1 = ra; rc2 = rb;
            #1;
            check($sformatf("rand%0d", i), dout, ref2(din, ra, rb));
            held = dout;
            rc1 = rb; rc2 = ra;
            #1;
            swp = ref2(din, rb, ra);
            if (dout !== held) act_diff++;
            if (swp !== ref2(din, ra, rb)) exp_diff++;
            if (i < 20) check($sformatf("swap%0d", i), dout, swp);
        end
        check64("swap_diff_count", 64'(act_diff), 64'(exp_diff));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
